// File: rtl/eq_coeff_pkg.sv
// Shared types and constants for the equalizer coefficient write path.
// The input register bank takes its default word width and set size from here as well.
package eq_coeff_pkg;

    localparam int DEFAULT_COEF_W    = 16;
    localparam int DEFAULT_NUM_COEFS = 64;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMMIT,
        WAIT_ACK
    } state_t;

    localparam logic [1:0] ERR_NONE        = 2'd0;
    localparam logic [1:0] ERR_EARLY_LAST  = 2'd1;
    localparam logic [1:0] ERR_NO_LAST     = 2'd2;
    localparam logic [1:0] ERR_ACK_TIMEOUT = 2'd3;

endpackage

// File: rtl/coeff_write_sequencer.sv
// Streams one coefficient set into sequential register-bank addresses.
// Holds write_done until the filter core acknowledges that it has adopted the set.
module coeff_write_sequencer
    import eq_coeff_pkg::*;
#(
    parameter int COEF_W      = DEFAULT_COEF_W,
    parameter int NUM_COEFS   = DEFAULT_NUM_COEFS,
    parameter int ADDR_W      = 6,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_enable,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [COEF_W-1:0] s_data,
    input  logic              s_last,
    output logic              o_write_enable,
    output logic [ADDR_W-1:0] o_write_address,
    output logic [COEF_W-1:0] o_coeff,
    output logic              o_write_done,
    input  logic              i_coeffs_en,
    output logic              o_busy,
    output logic              o_err,
    output logic [1:0]        o_err_code
);

    localparam int CNT_W = ADDR_W + 1;
    localparam int TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam bit TIMEOUT_EN = (ACK_TIMEOUT != 0);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_COEFS - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [TMR_W-1:0] timer;
    logic             we_q;
    logic             err_q;
    logic             accept;

    assign s_ready = clk_enable & ((state == IDLE) | (state == LOAD));
    assign accept  = s_valid & s_ready;
    assign o_busy  = (state != IDLE);

    // Strobes are held across disabled cycles and masked, so every write lands in an enabled cycle.
    assign o_write_enable = we_q & clk_enable;
    assign o_err          = err_q & clk_enable;

    // NOTE: all state is written with <= so every branch reads pre-edge values, like the flops do.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            count           <= '0;
            timer           <= '0;
            we_q            <= 1'b0;
            err_q           <= 1'b0;
            o_write_address <= '0;
            o_coeff         <= '0;
            o_write_done    <= 1'b0;
            o_err_code      <= ERR_NONE;
        end else if (clk_enable) begin
            we_q  <= accept;
            err_q <= 1'b0;
            if (accept) begin
                o_write_address <= count[ADDR_W-1:0];
                o_coeff         <= s_data;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        if (s_last) begin
                            err_q      <= 1'b1;
                            o_err_code <= ERR_EARLY_LAST;
                        end else begin
                            count <= CNT_W'(1);
                            state <= LOAD;
                        end
                    end
                end

                LOAD: begin
                    if (accept) begin
                        if (count == LAST_IDX) begin
                            count <= '0;
                            if (s_last) begin
                                state <= COMMIT;
                            end else begin
                                err_q      <= 1'b1;
                                o_err_code <= ERR_NO_LAST;
                                state      <= IDLE;
                            end
                        end else if (s_last) begin
                            err_q      <= 1'b1;
                            o_err_code <= ERR_EARLY_LAST;
                            count      <= '0;
                            state      <= IDLE;
                        end else begin
                            count <= count + CNT_W'(1);
                        end
                    end
                end

                // One spare cycle so the final word is in the bank before write_done rises.
                COMMIT: begin
                    timer        <= '0;
                    o_write_done <= 1'b1;
                    state        <= WAIT_ACK;
                end

                WAIT_ACK: begin
                    if (i_coeffs_en) begin
                        timer        <= '0;
                        o_write_done <= 1'b0;
                        state        <= IDLE;
                    end else if (TIMEOUT_EN && (timer == TMR_LAST)) begin
                        timer        <= '0;
                        o_write_done <= 1'b0;
                        err_q        <= 1'b1;
                        o_err_code   <= ERR_ACK_TIMEOUT;
                        state        <= IDLE;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_coeff_write_sequencer.sv
// Directed bench for coeff_write_sequencer with a 4-word set and an 8-cycle acknowledge timeout.
// Expected values are hand-derived per vector; the write log is compared against the sent words.
module tb_coeff_write_sequencer;

    localparam int COEF_W      = 16;
    localparam int NUM_COEFS   = 4;
    localparam int ADDR_W      = 6;
    localparam int ACK_TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              clk_enable;
    logic              s_valid;
    logic              s_ready;
    logic [COEF_W-1:0] s_data;
    logic              s_last;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [COEF_W-1:0] coeff;
    logic              done;
    logic              coeffs_en;
    logic              busy;
    logic              err;
    logic [1:0]        err_code;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [COEF_W-1:0] d;
    } wr_t;
    wr_t wr_log[$];

    logic [COEF_W-1:0] words [4] = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};

    coeff_write_sequencer #(
        .COEF_W     (COEF_W),
        .NUM_COEFS  (NUM_COEFS),
        .ADDR_W     (ADDR_W),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .clk_enable     (clk_enable),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .s_last         (s_last),
        .o_write_enable (we),
        .o_write_address(addr),
        .o_coeff        (coeff),
        .o_write_done   (done),
        .i_coeffs_en    (coeffs_en),
        .o_busy         (busy),
        .o_err          (err),
        .o_err_code     (err_code)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (we) wr_log.push_back('{a: addr, d: coeff});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [COEF_W-1:0] d, input logic last, input int exp_addr);
        // NOTE: stimulus uses blocking assignments a cycle away from the sampling edge.
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
        check("wr_en", 32'(we), 1);
        check("wr_addr", 32'(addr), 32'(exp_addr));
        check("wr_data", 32'(coeff), 32'(d));
    endtask

    task automatic full_set();
        for (int i = 0; i < NUM_COEFS; i++) beat(words[i], i == NUM_COEFS - 1, i);
    endtask

    // Entered one cycle after the final beat; acknowledges ack_delay cycles after write_done rises.
    task automatic finish_with_ack(input int ack_delay);
        check("commit_busy", 32'(busy), 1);
        check("commit_done", 32'(done), 0);
        tick();
        check("done_rise", 32'(done), 1);
        repeat (ack_delay) begin
            tick();
            check("done_hold", 32'(done), 1);
        end
        coeffs_en = 1'b1;
        tick();
        coeffs_en = 1'b0;
        check("done_fall", 32'(done), 0);
        check("idle_busy", 32'(busy), 0);
        check("idle_ready", 32'(s_ready), 1);
        check("ack_no_err", 32'(err), 0);
    endtask

    initial begin
        int idx;
        bit accepted;

        rst        = 1'b1;
        clk_enable = 1'b0;
        s_valid    = 1'b0;
        s_data     = '0;
        s_last     = 1'b0;
        coeffs_en  = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(s_ready), 0);
        check("rst_we", 32'(we), 0);
        check("rst_addr", 32'(addr), 0);
        check("rst_coeff", 32'(coeff), 0);
        check("rst_done", 32'(done), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(err), 0);
        check("rst_code", 32'(err_code), 0);
        rst        = 1'b0;
        clk_enable = 1'b1;
        #1;
        check("en_ready", 32'(s_ready), 1);
        tick();

        // Normal set, acknowledge 5 cycles after write_done rises
        full_set();
        check("commit_ready", 32'(s_ready), 0);
        finish_with_ack(5);
        check("ok_code", 32'(err_code), 0);

        // Acknowledge outside WAIT_ACK is ignored
        coeffs_en = 1'b1;
        tick();
        coeffs_en = 1'b0;
        check("stray_ack_busy", 32'(busy), 0);
        check("stray_ack_done", 32'(done), 0);

        // s_last on the very first word: written, flagged, stays idle
        beat(16'h0055, 1'b1, 0);
        check("first_last_err", 32'(err), 1);
        check("first_last_code", 32'(err_code), 1);
        check("first_last_busy", 32'(busy), 0);
        tick();
        check("err_pulse_end", 32'(err), 0);

        // s_last on the 2nd word, then a clean set from address 0
        beat(16'h000a, 1'b0, 0);
        beat(16'h000b, 1'b1, 1);
        check("early_err", 32'(err), 1);
        check("early_code", 32'(err_code), 1);
        check("early_busy", 32'(busy), 0);
        tick();
        check("early_err_end", 32'(err), 0);
        check("early_no_done", 32'(done), 0);
        full_set();
        finish_with_ack(1);

        // Four words with no s_last
        for (int i = 0; i < NUM_COEFS; i++) beat(words[i], 1'b0, i);
        check("nolast_err", 32'(err), 1);
        check("nolast_code", 32'(err_code), 2);
        check("nolast_busy", 32'(busy), 0);
        tick();
        check("nolast_err_end", 32'(err), 0);
        check("nolast_no_done", 32'(done), 0);

        // No acknowledge: write_done high for 8 enabled cycles, then timeout
        full_set();
        tick();
        check("to_done_rise", 32'(done), 1);
        repeat (ACK_TIMEOUT - 1) begin
            tick();
            check("to_done_hold", 32'(done), 1);
            check("to_no_err", 32'(err), 0);
        end
        tick();
        check("to_done_fall", 32'(done), 0);
        check("to_err", 32'(err), 1);
        check("to_code", 32'(err_code), 3);
        check("to_busy", 32'(busy), 0);
        tick();
        check("to_err_end", 32'(err), 0);
        check("to_code_hold", 32'(err_code), 3);

        // clk_enable toggling every cycle during a full set
        wr_log.delete();
        idx = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            clk_enable = (cyc % 2 == 0);
            s_valid    = (idx < NUM_COEFS);
            s_data     = (idx < NUM_COEFS) ? words[idx] : '0;
            s_last     = (idx == NUM_COEFS - 1);
            #1;
            if (!clk_enable) begin
                check("tog_we_gated", 32'(we), 0);
                check("tog_err_gated", 32'(err), 0);
                check("tog_ready_gated", 32'(s_ready), 0);
            end
            if (cyc == 8) check("tog_done_pre", 32'(done), 0);
            if (cyc == 10) check("tog_done_rise", 32'(done), 1);
            accepted = clk_enable && s_valid;
            tick();
            if (accepted) idx++;
        end
        clk_enable = 1'b1;
        s_valid    = 1'b0;
        s_last     = 1'b0;
        coeffs_en  = 1'b1;
        tick();
        coeffs_en  = 1'b0;
        check("tog_done_fall", 32'(done), 0);
        check("tog_busy", 32'(busy), 0);
        check("tog_log_len", 32'(wr_log.size()), NUM_COEFS);
        for (int i = 0; i < NUM_COEFS && i < wr_log.size(); i++) begin
            check("tog_log_addr", 32'(wr_log[i].a), 32'(i));
            check("tog_log_data", 32'(wr_log[i].d), 32'(words[i]));
        end

        // Reset after 2 of 4 words, then a fresh set from address 0
        beat(16'h0101, 1'b0, 0);
        beat(16'h0202, 1'b0, 1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_we", 32'(we), 0);
        check("mid_rst_addr", 32'(addr), 0);
        check("mid_rst_coeff", 32'(coeff), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_code", 32'(err_code), 0);
        tick();
        rst = 1'b0;
        full_set();
        finish_with_ack(2);

        // Reset while waiting for acknowledge drops write_done without a clock edge
        full_set();
        tick();
        check("wr_done_before_rst", 32'(done), 1);
        #1;
        rst = 1'b1;
        #1;
        check("async_done_fall", 32'(done), 0);
        check("async_busy", 32'(busy), 0);
        tick();
        rst = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/coeff_write_sequencer.md
Name: coeff_write_sequencer

Overview:
Writer-side front end for the equalizer coefficient register bank. It accepts a stream of coefficient words over a valid/ready interface and writes them to sequential addresses of the input register bank. It then raises the write-done level and holds it until the filter core acknowledges adoption of the new set with its coefficient-enable strobe. It sits between the host/config interface and the input register, and drives the write_done signal consumed by the write-done capture logic.

Parameters:
COEF_W, 16, coefficient word width in bits
NUM_COEFS, 64, coefficients per complete set; legal range 2..2**ADDR_W
ADDR_W, 6, register bank address width
ACK_TIMEOUT, 1024, clk_enable-qualified cycles to wait for acknowledge before flagging an error; 0 disables the timeout

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
clk_enable  in  1  global clock enable; state advances only when it is 1
s_valid  in  1  host coefficient word valid
s_ready  out  1  block can accept a word
s_data  in  COEF_W  coefficient word
s_last  in  1  marks the final word of a set
o_write_enable  out  1  register bank write strobe, one cycle per word
o_write_address  out  ADDR_W  register bank address
o_coeff  out  COEF_W  register bank write data
o_write_done  out  1  level; set written and awaiting adoption
i_coeffs_en  in  1  acknowledge from core; set adopted (phase 63 and capture)
o_busy  out  1  a set is in progress (state is not IDLE)
o_err  out  1  one-cycle error pulse
o_err_code  out  2  cause of the last error: 0 none, 1 early s_last, 2 missing s_last, 3 ack timeout

Behaviour:
- Reset values: s_ready=0, o_write_enable=0, o_write_address=0, o_coeff=0, o_write_done=0, o_busy=0, o_err=0, o_err_code=0, state=IDLE, count=0, timer=0.
- Accept condition: s_valid & s_ready & clk_enable.
- s_ready = clk_enable & (state==IDLE or state==LOAD). It is combinational from state.
- Write port outputs are registered. An accepted beat produces o_write_enable=1 with o_write_address=count and o_coeff=s_data on the next cycle. o_write_enable=0 in every other cycle, including cycles where clk_enable is 0.
- Beat count is tracked by count, ADDR_W+1 bits wide.
- IDLE:
  - Accept: count becomes 1, go to LOAD.
  - If s_last is set on this beat, abort: o_err pulse, o_err_code=1, stay in IDLE. The word is still written.
- LOAD:
  - Non-final accept (count < NUM_COEFS-1) with s_last=1: abort, o_err_code=1, count=0, go to IDLE.
  - Final accept (count == NUM_COEFS-1) with s_last=0: abort, o_err_code=2, go to IDLE.
  - Final accept with s_last=1: go to COMMIT.
  - Any other accept: count increments.
- COMMIT: single cycle that lets the last write land. Go to WAIT_ACK; o_write_done becomes 1 on entry to WAIT_ACK.
- WAIT_ACK:
  - o_write_done is held at 1. i_coeffs_en is sampled only when clk_enable=1.
  - i_coeffs_en=1: o_write_done becomes 0 on the next edge, go to IDLE.
  - Timer reaches ACK_TIMEOUT (when ACK_TIMEOUT != 0): o_write_done=0, o_err_code=3, go to IDLE.
  - An acknowledge and a timeout in the same cycle resolve as acknowledge; no error is raised.
- Writes from aborted sets are not rolled back. The core only adopts a set after write_done, so partial data is harmless.
- i_coeffs_en outside WAIT_ACK is ignored.
- clk_enable=0 freezes state, count, timer and all registered outputs except o_write_enable and o_err, which read 0.
- rst asserted mid-set clears everything immediately and the partial set is dropped. o_write_done falls asynchronously.
- Latency: from the final accepted beat, o_write_done rises 2 enabled cycles later.

Decomposition:
- Package eq_coeff_pkg holds:
  - State enum: IDLE, LOAD, COMMIT, WAIT_ACK.
  - Error code constants: ERR_NONE, ERR_EARLY_LAST, ERR_NO_LAST, ERR_ACK_TIMEOUT.
  - Default COEF_W and NUM_COEFS shared with the input register.
- No sub-module. The counter, timer and FSM form one block of about 200 lines.

Test Plan:
- NUM_COEFS=4, stream 0x0011, 0x0022, 0x0033, 0x0044 with s_last on the 4th word, i_coeffs_en pulsed 5 cycles after write_done rises -> writes at addresses 0..3 with matching data, o_write_done high from 2 cycles after the last beat until 1 cycle after i_coeffs_en, then back in IDLE with s_ready=1.
- NUM_COEFS=4, s_last on the 2nd word -> o_err pulse with code 1, o_write_done stays 0, next set starts again at address 0.
- NUM_COEFS=4, 4 words with no s_last -> o_err pulse with code 2, no write_done.
- ACK_TIMEOUT=8 with no i_coeffs_en -> o_write_done high for 8 enabled cycles, then drops with o_err pulse and code 3.
- clk_enable toggling 1/0 every cycle during a full set -> identical writes and write_done timing measured in enabled cycles; o_write_enable never high while clk_enable=0.
- rst asserted after 2 of 4 words -> all outputs at reset values, a fresh 4-word set then completes normally starting at address 0.
